// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM.
// States, opcodes, mux-select codes and the control-word bundle.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_OUT = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) ||
           (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Saturating 8-bit count of consecutive memory-wait cycles.
// expired flags the cycle on which the wait reaches LIMIT.
module mc_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIM_M1 = 8'(LIMIT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= 8'd0;
    end else if (enable && cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end

  // cnt holds completed waits; this cycle would be wait number cnt+1
  assign expired = enable && (cnt >= LIM_M1);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing FSM: state register, next-state,
// control-word decode, memory wait timeout and retire counter.
module multicycle_control
  import mips_mc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [5:0]       opcode,
  input  logic             Mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic             Halted,
  output logic             Illegal_op,
  output logic             Mem_timeout,
  output logic [CNT_W-1:0] Retired_count
);

  state_t           state_q, state_d;
  ctrl_t            ctrl;
  logic             tmr_en, tmr_clr, tmr_exp;
  logic             set_ill, set_tmo, retire;
  logic             ill_q, tmo_q;
  logic [CNT_W-1:0] cnt_q;

  assign tmr_en  = is_wait_state(state_q) && !Mem_ready;
  assign tmr_clr = !tmr_en || tmr_exp;

  mc_wait_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk     (CLK),
    .rst     (RESET),
    .clear   (tmr_clr),
    .enable  (tmr_en),
    .expired (tmr_exp)
  );

  always_comb begin
    state_d = state_q;
    set_ill = 1'b0;
    set_tmo = 1'b0;
    case (state_q)
      S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
        if (Mem_ready) begin
          unique case (1'b1)
            state_q == S_FETCH:    state_d = S_DECODE;
            state_q == S_MEM_READ: state_d = S_MEM_WB;
            default:               state_d = S_FETCH;
          endcase
        end else if (tmr_exp) begin
          state_d = S_HALT;
          set_tmo = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            state_d = S_HALT;
            set_ill = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:
        state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_WB:  state_d = S_FETCH;
      S_EXECUTE: state_d = S_R_WB;
      S_R_WB:    state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_ADDI_WB: state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_HALT;
    endcase
  end

  // FETCH is only ever re-entered from a completing final step
  assign retire = (state_d == S_FETCH) && (state_q != S_FETCH);

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = Mem_ready;
        ctrl.pc_write  = Mem_ready;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_BR;
      S_MEM_ADDR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_OUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JMP;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      default:   ctrl = '0;
    endcase
    if (RESET) ctrl = '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire)  cnt_q <= cnt_q + CNT_W'(1);
      if (set_ill) ill_q <= 1'b1;
      if (set_tmo) tmo_q <= 1'b1;
    end
  end

  assign PCWrite       = ctrl.pc_write;
  assign PCWriteCond   = ctrl.pc_write_cond;
  assign IorD          = ctrl.iord;
  assign MemRead       = ctrl.mem_read;
  assign MemWrite      = ctrl.mem_write;
  assign IRWrite       = ctrl.ir_write;
  assign MemtoReg      = ctrl.mem_to_reg;
  assign RegDst        = ctrl.reg_dst;
  assign RegWrite      = ctrl.reg_write;
  assign ALUSrcA       = ctrl.alu_src_a;
  assign ALUSrcB       = ctrl.alu_src_b;
  assign ALUOp         = ctrl.alu_op;
  assign PCSource      = ctrl.pc_source;
  assign State         = state_q;
  assign Halted        = (state_q == S_HALT);
  assign Illegal_op    = ill_q;
  assign Mem_timeout   = tmo_q;
  assign Retired_count = cnt_q;

endmodule
